// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter that lets two requesters share one single-port,
// byte-enabled RAM. Each transaction runs IDLE -> ACCESS -> ACK.
module ram_port_arbiter #(
  parameter int unsigned LENGTH                  = 32'h1000,
  parameter int unsigned WIDTH                   = 32,
  parameter int unsigned MINIMUM_SECTIONAL_WIDTH = 8,
  parameter int unsigned ADDRESS_WIDTH           = $clog2(LENGTH),
  parameter int unsigned BYTE_ENABLES            = WIDTH / MINIMUM_SECTIONAL_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0,
  input  logic                     req1,
  input  logic [BYTE_ENABLES-1:0]  we0,
  input  logic [BYTE_ENABLES-1:0]  we1,
  input  logic [ADDRESS_WIDTH-1:0] addr0,
  input  logic [ADDRESS_WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0]         wdata0,
  input  logic [WIDTH-1:0]         wdata1,
  output logic                     ack0,
  output logic                     ack1,
  output logic [WIDTH-1:0]         rdata0,
  output logic [WIDTH-1:0]         rdata1,
  output logic                     busy,
  output logic                     grant,
  output logic                     mem_cs,
  output logic                     mem_oe,
  output logic [BYTE_ENABLES-1:0]  mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  inout  wire  [WIDTH-1:0]         mem_data
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic                     prio_q, prio_d;
  logic                     grant_q, grant_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [BYTE_ENABLES-1:0]  be_q, be_d;
  logic [WIDTH-1:0]         wdata_q, wdata_d;
  logic [WIDTH-1:0]         rdata0_q, rdata0_d;
  logic [WIDTH-1:0]         rdata1_q, rdata1_d;
  logic                     ack0_q, ack0_d;
  logic                     ack1_q, ack1_d;
  logic                     busy_q, busy_d;
  logic                     cs_q, cs_d;
  logic                     oe_q, oe_d;
  logic [BYTE_ENABLES-1:0]  mwe_q, mwe_d;
  logic [ADDRESS_WIDTH-1:0] maddr_q, maddr_d;
  logic                     drive_q, drive_d;
  logic                     win;

  // State and output registers; reset drops every RAM control at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      prio_q   <= 1'b0;
      grant_q  <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      busy_q   <= 1'b0;
      cs_q     <= 1'b0;
      oe_q     <= 1'b0;
      mwe_q    <= '0;
      maddr_q  <= '0;
      drive_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      busy_q   <= busy_d;
      cs_q     <= cs_d;
      oe_q     <= oe_d;
      mwe_q    <= mwe_d;
      maddr_q  <= maddr_d;
      drive_q  <= drive_d;
    end
  end

  // Next state; RAM controls are computed for the state being entered so
  // they come straight out of flops during ACCESS.
  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    busy_d   = 1'b0;
    cs_d     = 1'b0;
    oe_d     = 1'b0;
    mwe_d    = '0;
    maddr_d  = '0;
    drive_d  = 1'b0;
    win      = req1 & (~req0 | prio_q);

    case (state_q)
      ST_IDLE: begin
        if (req0 | req1) begin
          state_d = ST_ACCESS;
          grant_d = win;
          addr_d  = win ? addr1 : addr0;
          be_d    = win ? we1 : we0;
          wdata_d = win ? wdata1 : wdata0;
          busy_d  = 1'b1;
          cs_d    = 1'b1;
          maddr_d = addr_d;
          if (|be_d) begin
            mwe_d   = be_d;
            drive_d = 1'b1;
          end else begin
            oe_d = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        state_d = ST_ACK;
        busy_d  = 1'b1;
        ack0_d  = ~grant_q;
        ack1_d  = grant_q;
        // The RAM is driving the bus this cycle on a read.
        if (~|be_q) begin
          if (grant_q) rdata1_d = mem_data;
          else         rdata0_d = mem_data;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        prio_d  = ~grant_q;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign mem_data    = drive_q ? wdata_q : {WIDTH{1'bz}};
  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign rdata0      = rdata0_q;
  assign rdata1      = rdata1_q;
  assign busy        = busy_q;
  assign grant       = grant_q;
  assign mem_cs      = cs_q;
  assign mem_oe      = oe_q;
  assign mem_we      = mwe_q;
  assign mem_address = maddr_q;

endmodule
